mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory arbiter: FSM state
// encoding, the read-data pattern returned on an aborted access, the
// default timeout/starvation limits and a counter-width helper.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_I_WAIT = 2'd1;
    localparam logic [1:0] ST_D_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [31:0] ABORT_RDATA = 32'hDEADBEEF;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int MAXSKIP_DEFAULT = 3;

    // Bits needed for a counter that must be able to hold maxval.
    function automatic int cnt_width(input int maxval);
        int w;
        w = 1;
        while ((1 << w) <= maxval) w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single shared memory. The data (mem-stage)
// port has fixed priority; the instruction (fetch) port is forced through
// after MAXSKIP consecutive losses. Each access is granted from IDLE, waits
// for m_ack (bounded by TIMEOUT), then spends one RESP cycle pulsing the
// owner's ready before returning to IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int MAXSKIP = MAXSKIP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,

    output logic        stall,
    output logic        err
);

    localparam int WW = cnt_width(TIMEOUT);
    localparam int SW = cnt_width(MAXSKIP);

    // wait_cnt value during the last WAIT cycle allowed before the abort.
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [SW-1:0] SKIP_MAX  = SW'(MAXSKIP);
    localparam logic [SW-1:0] SKIP_ONE  = SW'(1);

    logic [1:0]    state_q,   state_d;
    logic          m_req_q,   m_req_d;
    logic          m_we_q,    m_we_d;
    logic [31:0]   m_addr_q,  m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic          err_q,     err_d;
    logic [SW-1:0] skip_q,    skip_d;
    logic [WW-1:0] wait_q,    wait_d;
    logic          grant_i;

    // Next-state logic: arbitration in IDLE, ack/timeout handling in WAIT.
    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        err_d     = err_q;
        skip_d    = skip_q;
        wait_d    = wait_q;
        grant_i   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // Data wins unless the fetch port has been starved long enough.
                    grant_i = i_req && (!d_req || (skip_q == SKIP_MAX));
                    m_req_d = 1'b1;
                    wait_d  = '0;
                    if (grant_i) begin
                        state_d   = ST_I_WAIT;
                        m_addr_d  = i_addr;
                        m_we_d    = 1'b0;
                        m_wdata_d = '0;
                        skip_d    = '0;
                    end else begin
                        state_d   = ST_D_WAIT;
                        m_addr_d  = d_addr;
                        m_we_d    = d_we;
                        m_wdata_d = d_wdata;
                        if (i_req && (skip_q != SKIP_MAX)) begin
                            skip_d = skip_q + SKIP_ONE;
                        end
                    end
                end
            end

            ST_I_WAIT, ST_D_WAIT: begin
                if (m_ack) begin
                    // A late ack on the final allowed cycle still completes normally.
                    state_d = ST_RESP;
                    m_req_d = 1'b0;
                    if (state_q == ST_I_WAIT) begin
                        i_rdata_d = m_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = m_rdata;
                        d_ready_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    wait_d  = wait_q + WAIT_ONE;
                    if (state_q == ST_I_WAIT) begin
                        i_rdata_d = ABORT_RDATA;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = ABORT_RDATA;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            skip_q    <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
            skip_q    <= skip_d;
            wait_q    <= wait_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign err     = err_q;

    // A requester stalls the pipeline while it asks and has not been served.
    assign stall = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory responder, all checked every cycle
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int TMO = 15;
    localparam int MSK = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        stall;
    logic        err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mem_arbiter #(.TIMEOUT(TMO), .MAXSKIP(MSK)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 = free, 1 = access outstanding,
    // 2 = response cycle. Owner 1 = instruction port, 2 = data port.
    int          mp, mown, mage, mskip;
    logic [31:0] maddr, mwdata, mirdata, mdrdata;
    logic        mwe, merr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mp <= 0; mown <= 0; mage <= 0; mskip <= 0;
            maddr <= '0; mwe <= 1'b0; mwdata <= '0;
            mirdata <= '0; mdrdata <= '0; merr <= 1'b0;
        end else begin
            case (mp)
                0: if (i_req || d_req) begin
                    if (i_req && (!d_req || mskip == MSK)) begin
                        mown <= 1; maddr <= i_addr; mwe <= 1'b0; mwdata <= '0; mskip <= 0;
                    end else begin
                        mown <= 2; maddr <= d_addr; mwe <= d_we; mwdata <= d_wdata;
                        if (i_req) mskip <= (mskip + 1 > MSK) ? MSK : mskip + 1;
                    end
                    mage <= 0;
                    mp <= 1;
                end
                1: if (m_ack) begin
                    if (mown == 1) mirdata <= m_rdata; else mdrdata <= m_rdata;
                    mp <= 2;
                end else if (mage + 1 >= TMO) begin
                    if (mown == 1) mirdata <= 32'hDEADBEEF; else mdrdata <= 32'hDEADBEEF;
                    merr <= 1'b1;
                    mp <= 2;
                end else begin
                    mage <= mage + 1;
                end
                default: mp <= 0;
            endcase
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic ei, ed;
            ei = (mp == 2) && (mown == 1);
            ed = (mp == 2) && (mown == 2);
            cmp("m_req",   {31'd0, m_req},   {31'd0, mp == 1});
            cmp("m_we",    {31'd0, m_we},    {31'd0, mwe});
            cmp("m_addr",  m_addr,  maddr);
            cmp("m_wdata", m_wdata, mwdata);
            cmp("i_rdata", i_rdata, mirdata);
            cmp("d_rdata", d_rdata, mdrdata);
            cmp("i_ready", {31'd0, i_ready}, {31'd0, ei});
            cmp("d_ready", {31'd0, d_ready}, {31'd0, ed});
            cmp("err",     {31'd0, err},     {31'd0, merr});
            cmp("stall",   {31'd0, stall},   {31'd0, (i_req & ~ei) | (d_req & ~ed)});
            cmp("one_ready", {31'd0, i_ready & d_ready}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int ack_mode = 2;

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #1;
        cmp("rst_m_req", {31'd0, m_req}, 32'd0);
        cmp("rst_m_addr", m_addr, 32'd0);
        cmp("rst_d_rdata", d_rdata, 32'd0);
        cmp("rst_err", {31'd0, err}, 32'd0);
        i_req = 1'b1; i_addr = 32'h10;
        chk_en = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;

        // Single fetch, granted on the first edge after reset release
        step();
        cmp("A_m_req", {31'd0, m_req}, 32'd1);
        cmp("A_m_addr", m_addr, 32'h10);
        cmp("A_m_we", {31'd0, m_we}, 32'd0);
        cmp("A_stall", {31'd0, stall}, 32'd1);
        m_ack = 1'b1; m_rdata = 32'hCAFE0001;
        step();
        cmp("A_i_ready", {31'd0, i_ready}, 32'd1);
        cmp("A_i_rdata", i_rdata, 32'hCAFE0001);
        cmp("A_m_req_drop", {31'd0, m_req}, 32'd0);
        m_ack = 1'b0; i_req = 1'b0;
        step();
        cmp("A_i_ready_pulse", {31'd0, i_ready}, 32'd0);

        // Simultaneous requests: data write first, fetch after one IDLE cycle
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        step();
        cmp("B_d_addr", m_addr, 32'h40);
        cmp("B_d_we", {31'd0, m_we}, 32'd1);
        cmp("B_d_wdata", m_wdata, 32'h1234);
        cmp("B_stall1", {31'd0, stall}, 32'd1);
        m_ack = 1'b1; m_rdata = 32'h55;
        step();
        cmp("B_d_ready", {31'd0, d_ready}, 32'd1);
        cmp("B_stall2", {31'd0, stall}, 32'd1);
        m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        cmp("B_idle_m_req", {31'd0, m_req}, 32'd0);
        cmp("B_stall3", {31'd0, stall}, 32'd1);
        step();
        cmp("B_i_addr", m_addr, 32'h20);
        cmp("B_i_we", {31'd0, m_we}, 32'd0);
        cmp("B_i_wdata", m_wdata, 32'd0);
        m_ack = 1'b1; m_rdata = 32'h77;
        step();
        cmp("B_i_rdata", i_rdata, 32'h77);
        m_ack = 1'b0; i_req = 1'b0;
        step();

        // Starvation guard: D,D,D,I twice with both ports requesting
        i_req = 1'b1; i_addr = 32'h90;
        d_req = 1'b1; d_addr = 32'h80;
        for (int k = 0; k < 8; k++) begin
            step();
            cmp("C_winner", m_addr, (k % 4 == 3) ? 32'h90 : 32'h80);
            m_ack = 1'b1; m_rdata = $urandom;
            step();
            m_ack = 1'b0;
            if (k == 7) begin i_req = 1'b0; d_req = 1'b0; end
            step();
        end

        // Ack on the last allowed WAIT cycle completes normally
        d_req = 1'b1; d_addr = 32'h100;
        step();
        for (int k = 0; k < TMO - 1; k++) step();
        cmp("D_m_req_w15", {31'd0, m_req}, 32'd1);
        m_ack = 1'b1; m_rdata = 32'hABCD;
        step();
        cmp("D_d_ready", {31'd0, d_ready}, 32'd1);
        cmp("D_d_rdata", d_rdata, 32'hABCD);
        cmp("D_err", {31'd0, err}, 32'd0);
        m_ack = 1'b0; d_req = 1'b0;
        step();

        // No ack at all: abort after TIMEOUT WAIT cycles, sticky err
        d_req = 1'b1; d_addr = 32'h104;
        step();
        for (int k = 0; k < TMO - 1; k++) step();
        cmp("E_m_req_w15", {31'd0, m_req}, 32'd1);
        step();
        cmp("E_m_req", {31'd0, m_req}, 32'd0);
        cmp("E_d_rdata", d_rdata, 32'hDEADBEEF);
        cmp("E_d_ready", {31'd0, d_ready}, 32'd1);
        cmp("E_err", {31'd0, err}, 32'd1);
        d_req = 1'b0;
        step(); step(); step();
        cmp("E_err_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of a data wait, followed by a stray ack
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hFFFF;
        step();
        step();
        rst = 1'b1;
        #1;
        cmp("F_m_req", {31'd0, m_req}, 32'd0);
        cmp("F_m_we", {31'd0, m_we}, 32'd0);
        cmp("F_m_addr", m_addr, 32'd0);
        cmp("F_m_wdata", m_wdata, 32'd0);
        cmp("F_d_rdata", d_rdata, 32'd0);
        cmp("F_err", {31'd0, err}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h1111;
        step();
        cmp("F_no_ready", {31'd0, d_ready | i_ready}, 32'd0);
        step();
        cmp("F_no_req", {31'd0, m_req}, 32'd0);
        m_ack = 1'b0;
        step();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step();
            if (k == 1500) rst = 1'b1;
            else if (k == 1501) rst = 1'b0;

            if (mp == 1) begin
                if (mage == 0) ack_mode = $urandom_range(0, 7);
                case (ack_mode)
                    0: m_ack = 1'b0;
                    1: m_ack = (mage == TMO - 1);
                    default: m_ack = $urandom_range(0, 1);
                endcase
            end else begin
                m_ack = ($urandom_range(0, 3) == 0);
            end
            m_rdata = $urandom;

            if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
            end else if (mp == 2 && mown == 1) begin
                if ($urandom_range(0, 1) == 1) i_addr = $urandom; else i_req = 1'b0;
            end else if (!(mp != 0 && mown == 1) && $urandom_range(0, 15) == 0) begin
                i_req = 1'b0;
            end

            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                    d_we = 1'($urandom_range(0, 1));
                end
            end else if (mp == 2 && mown == 2) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
                end else begin
                    d_req = 1'b0;
                end
            end else if (!(mp != 0 && mown == 2) && $urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
        end

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
